// File: rtl/sanduba_n.sv
// sanduba_n: parametrised vending controller with per-product prices,
// saturating coin credit, timed product delivery and optional auto-refund.
module sanduba_n #(
  parameter int                  NPROD       = 3,
  parameter int                  CW          = 5,
  parameter logic [NPROD*CW-1:0] PRICES      = {5'd5, 5'd4, 5'd3},
  parameter int                  DELIV_CYC   = 4,
  parameter bit                  AUTO_REFUND = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             m100,
  input  logic             dev,
  input  logic [NPROD-1:0] req,
  output logic [NPROD-1:0] deliver,
  output logic             d100,
  output logic             busy,
  output logic             nulo,
  output logic [CW-1:0]    count,
  output logic [2:0]       ea
);

  localparam logic [2:0] ACTION = 3'd0;
  localparam logic [2:0] SOMA   = 3'd1;
  localparam logic [2:0] SERVE  = 3'd2;
  localparam logic [2:0] REFUND = 3'd3;
  localparam logic [2:0] NULO   = 3'd4;

  localparam int SW = (NPROD > 1) ? $clog2(NPROD) : 1;
  localparam int TW = $clog2(DELIV_CYC + 1);

  logic [SW-1:0] sel, sel_n;
  logic [TW-1:0] timer, timer_n;
  logic [CW-1:0] count_n;
  logic [2:0]    ea_n;

  logic          multi;
  logic          hit;
  logic [SW-1:0] hit_idx;
  logic [CW-1:0] hit_price;

  // Request decode: reject multiple requests, find an affordable single one
  always_comb begin
    multi     = (req & (req - NPROD'(1))) != '0;
    hit       = 1'b0;
    hit_idx   = '0;
    hit_price = '0;
    for (int unsigned i = 0; i < NPROD; i++) begin
      if (req[i] && !multi && (count >= PRICES[CW*i +: CW])) begin
        hit       = 1'b1;
        hit_idx   = SW'(i);
        hit_price = PRICES[CW*i +: CW];
      end
    end
  end

  // Next-state and datapath update; inputs only matter in ACTION
  always_comb begin
    ea_n    = ea;
    count_n = count;
    timer_n = timer;
    sel_n   = sel;
    case (ea)
      ACTION: begin
        if (dev && (count != '0)) begin
          ea_n = REFUND;
        end else if (multi) begin
          ea_n = NULO;
        end else if (hit) begin
          ea_n    = SERVE;
          sel_n   = hit_idx;
          count_n = count - hit_price;
          timer_n = TW'(DELIV_CYC - 1);
        end else if (m100) begin
          ea_n = SOMA;
        end
      end
      SOMA: begin
        if (count != '1) count_n = count + CW'(1);
        ea_n = ACTION;
      end
      SERVE: begin
        if (timer == '0) begin
          ea_n = (AUTO_REFUND && (count != '0)) ? REFUND : ACTION;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      REFUND: begin
        // Guarded so a zero credit can never wrap; the last coin exits
        if (count <= CW'(1)) begin
          count_n = '0;
          ea_n    = ACTION;
        end else begin
          count_n = count - CW'(1);
        end
      end
      NULO:    ea_n = ACTION;
      default: ea_n = ACTION;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      ea    <= ACTION;
      count <= '0;
      timer <= '0;
      sel   <= '0;
    end else begin
      ea    <= ea_n;
      count <= count_n;
      timer <= timer_n;
      sel   <= sel_n;
    end
  end

  // Moore outputs decoded from the registered state
  always_comb begin
    busy = (ea != ACTION);
    nulo = (ea == NULO);
    d100 = (ea == REFUND) || ((ea == SOMA) && (count == '1));
    for (int unsigned i = 0; i < NPROD; i++) begin
      deliver[i] = (ea == SERVE) && (sel == SW'(i));
    end
  end

endmodule

// File: tb/tb_sanduba_n.sv
// tb_sanduba_n: scoreboard bench for sanduba_n (default, CW=3 and auto-refund builds).
module tb_sanduba_n;

  localparam logic [2:0] S_ACTION = 3'd0;
  localparam logic [2:0] S_SOMA   = 3'd1;
  localparam logic [2:0] S_SERVE  = 3'd2;
  localparam logic [2:0] S_REFUND = 3'd3;
  localparam logic [2:0] S_NULO   = 3'd4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       m100  = 1'b0;
  logic       dev   = 1'b0;
  logic [2:0] req   = '0;

  always #5 clock = ~clock;

  logic [2:0] del0, del1, del2;
  logic       d0, d1, d2, b0, b1, b2, n0, n1, n2;
  logic [4:0] cnt0, cnt2;
  logic [2:0] cnt1;
  logic [2:0] ea0, ea1, ea2;

  sanduba_n #(.NPROD(3), .CW(5), .PRICES({5'd5, 5'd4, 5'd3}), .DELIV_CYC(4), .AUTO_REFUND(1'b0)) u_dut (
    .clock(clock), .reset(reset), .m100(m100), .dev(dev), .req(req),
    .deliver(del0), .d100(d0), .busy(b0), .nulo(n0), .count(cnt0), .ea(ea0));

  sanduba_n #(.NPROD(3), .CW(3), .PRICES({3'd5, 3'd4, 3'd3}), .DELIV_CYC(4), .AUTO_REFUND(1'b0)) u_sat (
    .clock(clock), .reset(reset), .m100(m100), .dev(dev), .req(req),
    .deliver(del1), .d100(d1), .busy(b1), .nulo(n1), .count(cnt1), .ea(ea1));

  sanduba_n #(.NPROD(3), .CW(5), .PRICES({5'd5, 5'd4, 5'd3}), .DELIV_CYC(4), .AUTO_REFUND(1'b1)) u_auto (
    .clock(clock), .reset(reset), .m100(m100), .dev(dev), .req(req),
    .deliver(del2), .d100(d2), .busy(b2), .nulo(n2), .count(cnt2), .ea(ea2));

  // Observed vector {ea, count, deliver, d100, busy, nulo} of the instance under test
  int         which = 0;
  logic [13:0] obs;
  always_comb begin
    case (which)
      1:       obs = {ea1, 2'b00, cnt1, del1, d1, b1, n1};
      2:       obs = {ea2, cnt2, del2, d2, b2, n2};
      default: obs = {ea0, cnt0, del0, d0, b0, n0};
    endcase
  end

  typedef struct {
    string       tag;
    logic [13:0] v;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  int         checks = 0;
  int         passed = 0;
  logic [4:0] mc = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic expect_out(input string tag, input logic [2:0] e, input logic [4:0] c,
                            input logic [2:0] d, input logic dd, input logic b, input logic n);
    exp_t x;
    x.tag = tag;
    x.v   = {e, c, d, dd, b, n};
    sb.push_back(x);
  endtask

  // One expected output snapshot is consumed per cycle, just after each edge
  always @(posedge clock) begin
    #1;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      check_eq(cur.tag, {18'd0, obs}, {18'd0, cur.v});
    end
  end

  task automatic apply(input logic m, input logic d, input logic [2:0] r);
    @(negedge clock);
    m100 = m;
    dev  = d;
    req  = r;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clock);
    m100 = 1'b0;
    dev  = 1'b0;
    req  = '0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      check_eq("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    m100  = 1'b0;
    dev   = 1'b0;
    req   = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    mc    = '0;
  endtask

  task automatic coin(input logic [4:0] maxc);
    apply(1'b1, 1'b0, 3'b000);
    if (mc == maxc) begin
      expect_out("coin_reject", S_SOMA, mc, 3'b000, 1'b1, 1'b1, 1'b0);
      expect_out("coin_sat", S_ACTION, mc, 3'b000, 1'b0, 1'b0, 1'b0);
    end else begin
      expect_out("coin_soma", S_SOMA, mc, 3'b000, 1'b0, 1'b1, 1'b0);
      mc = mc + 5'd1;
      expect_out("coin_done", S_ACTION, mc, 3'b000, 1'b0, 1'b0, 1'b0);
    end
    drain();
  endtask

  task automatic buy(input logic [2:0] r, input logic [4:0] price, input bit auto_ref);
    apply(1'b0, 1'b0, r);
    mc = mc - price;
    repeat (4) expect_out("buy_serve", S_SERVE, mc, r, 1'b0, 1'b1, 1'b0);
    if (auto_ref) begin
      while (mc != 0) begin
        expect_out("buy_refund", S_REFUND, mc, 3'b000, 1'b1, 1'b1, 1'b0);
        mc = mc - 5'd1;
      end
    end
    expect_out("buy_done", S_ACTION, mc, 3'b000, 1'b0, 1'b0, 1'b0);
    drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Saturation on the 3-bit credit build
    which = 1;
    do_reset();
    check_eq("sat_reset", {18'd0, obs}, 32'd0);
    repeat (7) coin(5'd7);
    coin(5'd7);

    // Auto-refund after purchase
    which = 2;
    do_reset();
    repeat (5) coin(5'd31);
    buy(3'b010, 5'd4, 1'b1);

    // Default build
    which = 0;
    do_reset();
    check_eq("reset_state", {18'd0, obs}, 32'd0);
    repeat (2) coin(5'd31);

    apply(1'b0, 1'b0, 3'b100);
    expect_out("poor_idle", S_ACTION, 5'd2, 3'b000, 1'b0, 1'b0, 1'b0);
    expect_out("poor_idle2", S_ACTION, 5'd2, 3'b000, 1'b0, 1'b0, 1'b0);
    drain();

    repeat (3) coin(5'd31);
    buy(3'b010, 5'd4, 1'b0);
    repeat (8) coin(5'd31);

    apply(1'b0, 1'b0, 3'b011);
    expect_out("bad_nulo", S_NULO, 5'd9, 3'b000, 1'b0, 1'b1, 1'b1);
    expect_out("bad_done", S_ACTION, 5'd9, 3'b000, 1'b0, 1'b0, 1'b0);
    drain();

    buy(3'b100, 5'd5, 1'b0);

    // dev wins over m100 and req; coins during REFUND are ignored
    apply(1'b1, 1'b1, 3'b001);
    for (int c = 4; c >= 1; c--)
      expect_out("prio_refund", S_REFUND, 5'(c), 3'b000, 1'b1, 1'b1, 1'b0);
    expect_out("prio_done", S_ACTION, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    mc = '0;
    @(negedge clock);
    dev = 1'b0;
    req = '0;
    @(negedge clock);
    @(negedge clock);
    m100 = 1'b0;
    drain();

    apply(1'b0, 1'b1, 3'b000);
    expect_out("dev_zero", S_ACTION, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    expect_out("dev_zero2", S_ACTION, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    drain();

    // Reset held two cycles in the middle of a delivery
    repeat (5) coin(5'd31);
    apply(1'b0, 1'b0, 3'b010);
    expect_out("rst_serve", S_SERVE, 5'd1, 3'b010, 1'b0, 1'b1, 1'b0);
    @(negedge clock);
    req   = '0;
    reset = 1'b0;
    expect_out("rst_mid1", S_ACTION, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    expect_out("rst_mid2", S_ACTION, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    expect_out("rst_after", S_ACTION, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    mc = '0;
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sanduba_n.md
# sanduba_n

Parametrised vending controller generalising the three-product sandwich machine. It supports NPROD products with per-product prices, a CW-bit saturating coin credit, a programmable delivery time and an optional automatic change-return mode. It sits between the user-input debouncers and the product/coin actuators. The exposed state (`ea`) and credit (`count`) feed the formal property bench.

## Interface
- NPROD, 3: number of products (≥1)
- CW, 5: credit counter width; one unit = one 100 coin
- PRICES, {5'd5,5'd4,5'd3}: packed NPROD*CW bits; price of product i at [CW*i +: CW]; 0 allowed
- DELIV_CYC, 4: cycles `deliver[i]` is held (≥1)
- AUTO_REFUND, 0: 1 = return remaining credit automatically after each delivery
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- m100  in  1  coin inserted (one unit)
- dev  in  1  refund request
- req  in  NPROD  product request, one bit per product
- deliver  out  NPROD  product release, one-hot while serving
- d100  out  1  one coin returned per high cycle
- busy  out  1  controller not accepting input
- nulo  out  1  bad-input flag (multiple simultaneous requests)
- count  out  CW  current credit
- ea  out  3  current state: ACTION=0, SOMA=1, SERVE=2, REFUND=3, NULO=4

## Operation
- Reset (reset=0 at an edge): ea=ACTION, count=0, serve timer=0; all outputs 0. Reset applies from any state, including mid-SERVE or mid-REFUND.
- Outputs are Moore, decoded from the state register only:
  - `busy` = (ea≠ACTION)
  - `deliver[sel]` = (ea==SERVE)
  - `d100` = (ea==REFUND) or (ea==SOMA and coin rejected)
  - `nulo` = (ea==NULO)
- ACTION samples inputs and applies the first matching rule; all lower-priority inputs in that cycle are dropped:
  1. dev and count>0 → REFUND.
  2. popcount(req)≥2 → NULO; count unchanged.
  3. One req[i] and count ≥ PRICES[i] → SERVE; latch sel=i; count ← count−PRICES[i]; timer ← DELIV_CYC−1.
  4. m100 → SOMA; latch the coin.
  5. Otherwise stay. A single request with insufficient credit and dev with count=0 are ignored.
- SOMA (1 cycle):
  - count<2^CW−1: count ← count+1.
  - count==2^CW−1: coin rejected, d100=1 this cycle, count unchanged.
  - Next state → ACTION.
- SERVE: timer decrements each cycle. At timer==0 → REFUND if AUTO_REFUND and count>0, else → ACTION.
- REFUND: d100=1 and count ← count−1 each cycle. When count reaches 1 (last coin) → ACTION. Exactly N pulses for credit N.
- NULO (1 cycle): nulo=1, busy=1 → ACTION.
- All inputs are ignored in every state except ACTION.
- Arithmetic is unsigned CW-bit. The subtraction cannot underflow (guarded by rule 3). The increment saturates.
- Unused `ea` encodings 5–7 → ACTION with count preserved.

## Timing
- Input sampled at edge k in ACTION → new state visible from k+1; busy=1 from k+1.
- Coin: m100 at edge k → ea=SOMA during k+1 → count+1 visible from k+2.
- Purchase: req at edge k → deliver high for cycles k+1 … k+DELIV_CYC, and the reduced count is visible from k+1. ea=ACTION (or REFUND) at k+DELIV_CYC+1.
- Refund of N: d100 high for cycles k+1 … k+N; count=0 and ea=ACTION at k+N+1.
- Bad input: busy=nulo=1 at k+1 only; ACTION at k+2.
- Minimum spacing between accepted inputs is 2 cycles.

## Test plan
- Reset: drive reset=0 for 2 cycles in mid-SERVE → next cycle ea=0, count=0, deliver=0, busy=0.
- Coins: 5× m100, each applied in ACTION → count=5 two cycles after the last coin; busy high exactly one cycle per coin. With CW=3 at count=7, m100 → d100 one cycle, count stays 7.
- Purchase: count=5, req=3'b010 → count=1 at k+1, deliver=3'b010 for 4 cycles, then ACTION with count=1. With AUTO_REFUND=1: one d100 pulse follows, then count=0.
- Insufficient credit: count=2, req=3'b100 → no state change, busy=0, count=2.
- Bad input: req=3'b011 with count=9 → nulo=1 and busy=1 for one cycle, count=9, no deliver.
- Priority/ignore: dev+m100+req=3'b001 with count=4 → 4 d100 pulses, count=0. m100 pulses applied during REFUND are not counted.
